// File: rtl/tachyon_fetch_arbiter.sv
// tachyon_fetch_arbiter
// Shares one single-port word RAM between NR_CORES instruction-fetch ports
// and a debug memory channel. Debug has absolute priority; cores are served
// round-robin and can be blocked with i_dbg_halt. Responses return exactly
// one cycle after the grant.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_core_req/i_core_addr  per-core fetch request and packed word address
//   o_core_gnt              one-hot core grant (combinational)
//   o_core_rsp_valid/_data  registered one-hot valid, shared fetch data
//   i_dbg_*                 debug request, write flag, address, data, halt
//   o_dbg_gnt               debug grant (combinational)
//   o_dbg_rsp_valid/_rdata  registered debug completion and read data
//   o_ram_*/i_ram_rd_data   RAM read/write ports (read data 1 cycle later)
module tachyon_fetch_arbiter #(
    parameter int unsigned NR_CORES   = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NR_CORES-1:0]                i_core_req,
    input  logic [NR_CORES*(ADDR_WIDTH-2)-1:0] i_core_addr,
    output logic [NR_CORES-1:0]                o_core_gnt,
    output logic [NR_CORES-1:0]                o_core_rsp_valid,
    output logic [DATA_WIDTH-1:0]              o_core_rsp_data,
    input  logic                               i_dbg_req,
    input  logic                               i_dbg_wr,
    input  logic [ADDR_WIDTH-3:0]              i_dbg_addr,
    input  logic [DATA_WIDTH-1:0]              i_dbg_wdata,
    input  logic                               i_dbg_halt,
    output logic                               o_dbg_gnt,
    output logic                               o_dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0]              o_dbg_rdata,
    output logic                               o_ram_rd_en,
    output logic [ADDR_WIDTH-3:0]              o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]              i_ram_rd_data,
    output logic                               o_ram_wr_en,
    output logic [ADDR_WIDTH-3:0]              o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]              o_ram_wr_data
);

    localparam int unsigned AW    = ADDR_WIDTH - 2;
    localparam int unsigned PTR_W = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NR_CORES-1:0]   r_core_rsp_valid;
    logic                  r_dbg_rsp_valid;
    logic                  r_dbg_rd;
    logic [DATA_WIDTH-1:0] r_core_data;
    logic [DATA_WIDTH-1:0] r_dbg_data;

    logic                  w_core_hit;
    logic [PTR_W-1:0]      w_core_idx;
    logic [PTR_W-1:0]      w_scan_idx;
    logic                  w_core_sel;
    logic                  w_dbg_sel;
    logic [AW-1:0]         w_core_addr;
    logic [PTR_W-1:0]      w_rr_next;

    // Wrap a core index modulo NR_CORES.
    function automatic logic [PTR_W-1:0] f_wrap(input int unsigned v);
        return PTR_W'(v % NR_CORES);
    endfunction

    // Round-robin search: first requester at or after r_rr_ptr.
    always_comb begin
        w_core_hit = 1'b0;
        w_core_idx = '0;
        w_scan_idx = '0;
        for (int unsigned off = 0; off < NR_CORES; off++) begin
            w_scan_idx = f_wrap(32'(r_rr_ptr) + off);
            if (!w_core_hit && i_core_req[w_scan_idx]) begin
                w_core_hit = 1'b1;
                w_core_idx = w_scan_idx;
            end
        end
    end

    // Debug wins outright; cores only when debug idle and not halted.
    assign w_dbg_sel  = ~i_rst & i_dbg_req;
    assign w_core_sel = ~i_rst & ~i_dbg_req & ~i_dbg_halt & w_core_hit;
    assign w_rr_next  = f_wrap(32'(w_core_idx) + 32'd1);

    // One-hot grant decode and granted address mux.
    always_comb begin
        o_core_gnt  = '0;
        w_core_addr = '0;
        for (int unsigned i = 0; i < NR_CORES; i++) begin
            if (w_core_sel && (w_core_idx == PTR_W'(i))) begin
                o_core_gnt[i] = 1'b1;
                w_core_addr   = i_core_addr[i*AW +: AW];
            end
        end
    end

    assign o_dbg_gnt = w_dbg_sel;

    // RAM port drive; everything is zero when nothing is granted.
    always_comb begin
        o_ram_rd_en   = 1'b0;
        o_ram_rd_addr = '0;
        o_ram_wr_en   = 1'b0;
        o_ram_wr_addr = '0;
        o_ram_wr_data = '0;
        if (w_dbg_sel) begin
            if (i_dbg_wr) begin
                o_ram_wr_en   = 1'b1;
                o_ram_wr_addr = i_dbg_addr;
                o_ram_wr_data = i_dbg_wdata;
            end else begin
                o_ram_rd_en   = 1'b1;
                o_ram_rd_addr = i_dbg_addr;
            end
        end else if (w_core_sel) begin
            o_ram_rd_en   = 1'b1;
            o_ram_rd_addr = w_core_addr;
        end
    end

    // Response owner, round-robin pointer and held read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr         <= '0;
            r_core_rsp_valid <= '0;
            r_dbg_rsp_valid  <= 1'b0;
            r_dbg_rd         <= 1'b0;
            r_core_data      <= '0;
            r_dbg_data       <= '0;
        end else begin
            r_core_rsp_valid <= o_core_gnt;
            r_dbg_rsp_valid  <= w_dbg_sel;
            r_dbg_rd         <= w_dbg_sel & ~i_dbg_wr;
            if (w_core_sel) begin
                r_rr_ptr <= w_rr_next;
            end
            if (|r_core_rsp_valid) begin
                r_core_data <= i_ram_rd_data;
            end
            if (r_dbg_rd) begin
                r_dbg_data <= i_ram_rd_data;
            end
        end
    end

    // RAM data arrives in the response cycle; the registers hold it afterwards.
    assign o_core_rsp_valid = r_core_rsp_valid;
    assign o_dbg_rsp_valid  = r_dbg_rsp_valid;
    assign o_core_rsp_data  = (|r_core_rsp_valid) ? i_ram_rd_data : r_core_data;
    assign o_dbg_rdata      = r_dbg_rd ? i_ram_rd_data : r_dbg_data;

endmodule
